// File: rtl/seat_access_arbiter_pkg.sv
// Shared types, widths and request validation for the seat access arbiter.
package seat_pkg;

  localparam int STUDENT_W   = 25;
  localparam int SEAT_W      = 5;
  localparam int TIME_W      = 11;
  localparam int MIN_PER_DAY = 1440;

  typedef enum logic [1:0] {
    FREE     = 2'b00,
    AWAY     = 2'b01,
    OCCUPIED = 2'b11
  } seat_state_t;

  typedef enum logic [1:0] {
    OK        = 2'b00,
    ERR_SEAT  = 2'b01,
    ERR_STATE = 2'b10
  } resp_status_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } arb_state_t;

  // Seat range is checked before the state encoding, so a bad seat always
  // reports ERR_SEAT even when the state is also illegal.
  function automatic resp_status_t check_request(input logic [SEAT_W-1:0] seat,
                                                 input logic [1:0]        state,
                                                 input int                num_seats);
    if ((seat == '0) || (int'(seat) > num_seats)) return ERR_SEAT;
    if (state == 2'b10) return ERR_STATE;
    return OK;
  endfunction

endpackage

// File: rtl/seat_access_arbiter_if.sv
// Kiosk request / response bundle between the kiosks and the arbiter.
interface seat_access_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import seat_pkg::*;

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*STUDENT_W-1:0] req_student_no;
  logic [NUM_REQ*SEAT_W-1:0]    req_seat_no;
  logic [NUM_REQ*2-1:0]         req_seat_state;
  logic                         resp_valid;
  logic [ID_W-1:0]              resp_id;
  logic [1:0]                   resp_status;

  // Kiosk side
  modport master (
    output req_valid, req_student_no, req_seat_no, req_seat_state,
    input  req_ready, resp_valid, resp_id, resp_status
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_student_no, req_seat_no, req_seat_state,
    output req_ready, resp_valid, resp_id, resp_status
  );

endinterface

// File: rtl/seat_access_arbiter_time_counter.sv
// Minute-of-day clock: prescaler plus Time register with load and midnight wrap.
module seat_time_counter
  import seat_pkg::*;
#(
  parameter int TICKS_PER_MIN = 6000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              time_load_i,
  input  logic [TIME_W-1:0] time_load_val_i,
  output logic [TIME_W-1:0] time_o
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              tick;
  logic              load_ok;

  assign tick    = (presc_q == PW'(TICKS_PER_MIN - 1));
  assign load_ok = time_load_i && (time_load_val_i < TIME_W'(MIN_PER_DAY));

  // Next prescaler/Time: an in-range load beats a tick; an out-of-range load is a no-op.
  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    if (load_ok) begin
      presc_d = '0;
      time_d  = time_load_val_i;
    end else if (tick) begin
      presc_d = '0;
      time_d  = (time_q == TIME_W'(MIN_PER_DAY - 1)) ? '0 : time_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Prescaler and Time registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

  assign time_o = time_q;

endmodule

// File: rtl/seat_access_arbiter.sv
// Round-robin arbiter sharing the seat table's single write port among kiosks.
// Each grant is validated; only accepted requests produce a table write, and
// every grant is answered with one response pulse.
module seat_access_arbiter
  import seat_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NUM_SEATS     = 30,
  parameter int TICKS_PER_MIN = 6000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seat_access_arbiter_if.slave  req_if,
  input  logic                  time_load,
  input  logic [TIME_W-1:0]     time_load_val,
  output logic [STUDENT_W-1:0]  Student_No,
  output logic [SEAT_W-1:0]     Seat_No,
  output logic [1:0]            Seat_State,
  output logic                  write,
  output logic [TIME_W-1:0]     Time
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      win_id;
  logic                 win_found;
  int                   idx;
  logic                 grant;
  logic [NUM_REQ-1:0]   ready;

  logic [STUDENT_W-1:0] sel_student;
  logic [SEAT_W-1:0]    sel_seat;
  logic [1:0]           sel_state;
  resp_status_t         sel_status;

  logic [STUDENT_W-1:0] student_q;
  logic [SEAT_W-1:0]    seat_q;
  logic [1:0]           seat_state_q;
  logic [ID_W-1:0]      resp_id_q;
  resp_status_t         resp_status_q;

  // Round-robin search starting at the pointer (the kiosk after the last winner).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req_if.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign grant = (state_q == S_GRANT) && win_found;

  // Winner's fields and their validation result, only meaningful while granting.
  always_comb begin
    sel_student = req_if.req_student_no[int'(win_id)*STUDENT_W +: STUDENT_W];
    sel_seat    = req_if.req_seat_no[int'(win_id)*SEAT_W +: SEAT_W];
    sel_state   = req_if.req_seat_state[int'(win_id)*2 +: 2];
    sel_status  = check_request(sel_seat, sel_state, NUM_SEATS);
  end

  // FSM next state, one-hot ready pulse and pointer advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready   = '0;
    if (grant) begin
      ready[win_id] = 1'b1;
      ptr_d         = ID_W'((int'(win_id) + 1) % NUM_REQ);
    end
    case (state_q)
      S_IDLE:  if (|req_if.req_valid) state_d = S_GRANT;
      // A kiosk may withdraw between IDLE and GRANT; fall back to IDLE then.
      S_GRANT: begin
        if (!win_found)             state_d = S_IDLE;
        else if (sel_status == OK)  state_d = S_WRITE;
        else                        state_d = S_RESP;
      end
      S_WRITE: state_d = S_RESP;
      // Go straight to GRANT so back-to-back requests lose no cycle in IDLE.
      S_RESP:  state_d = (|req_if.req_valid) ? S_GRANT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Capture on grant: table fields only for accepted requests, so rejected
  // ones leave the table-side outputs holding their previous values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      student_q     <= '0;
      seat_q        <= '0;
      seat_state_q  <= '0;
      resp_id_q     <= '0;
      resp_status_q <= OK;
    end else if (grant) begin
      resp_id_q     <= win_id;
      resp_status_q <= sel_status;
      if (sel_status == OK) begin
        student_q    <= sel_student;
        seat_q       <= sel_seat;
        seat_state_q <= sel_state;
      end
    end
  end

  seat_time_counter #(
    .TICKS_PER_MIN (TICKS_PER_MIN)
  ) u_time (
    .clk             (clk),
    .rst_n           (rst_n),
    .time_load_i     (time_load),
    .time_load_val_i (time_load_val),
    .time_o          (Time)
  );

  assign req_if.req_ready   = ready;
  assign req_if.resp_valid  = (state_q == S_RESP);
  assign req_if.resp_id     = resp_id_q;
  assign req_if.resp_status = resp_status_q;

  assign write      = (state_q == S_WRITE);
  assign Student_No = student_q;
  assign Seat_No    = seat_q;
  assign Seat_State = seat_state_q;

endmodule

// File: tb/tb_seat_access_arbiter.sv
// Bench for seat_access_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, validation and time.
module tb_seat_access_arbiter;
  import seat_pkg::*;

  localparam int NR  = 4;
  localparam int NS  = 30;
  localparam int TPM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        time_load = 1'b0;
  logic [10:0] time_load_val = '0;
  logic [24:0] Student_No;
  logic [4:0]  Seat_No;
  logic [1:0]  Seat_State;
  logic        write;
  logic [10:0] Time;

  always #5 clk = ~clk;

  seat_access_arbiter_if #(.NUM_REQ(NR)) bus ();

  seat_access_arbiter #(
    .NUM_REQ       (NR),
    .NUM_SEATS     (NS),
    .TICKS_PER_MIN (TPM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_if        (bus.slave),
    .time_load     (time_load),
    .time_load_val (time_load_val),
    .Student_No    (Student_No),
    .Seat_No       (Seat_No),
    .Seat_State    (Seat_State),
    .write         (write),
    .Time          (Time)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic        m_valid [NR];
  logic [24:0] m_stu   [NR];
  logic [4:0]  m_seat  [NR];
  logic [1:0]  m_st    [NR];
  int          m_ptr = 0;
  logic [24:0] last_stu = '0;
  logic [4:0]  last_seat = '0;
  logic [1:0]  last_st = '0;
  int          t_base = 0;
  int          t_n0 = 0;
  int          cyc = 0;
  int          exp_writes = 0;
  int          wr_cnt = 0;
  int          overlap = 0;
  logic        prev_write = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write === 1'b1) wr_cnt++;
    if (write === 1'b1 && prev_write === 1'b1) overlap++;
    prev_write = write;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]              = m_valid[i];
      bus.req_student_no[25*i +: 25] = m_stu[i];
      bus.req_seat_no[5*i +: 5]      = m_seat[i];
      bus.req_seat_state[2*i +: 2]   = m_st[i];
    end
  endtask

  function automatic int exp_winner();
    for (int k = 0; k < NR; k++)
      if (m_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic int model_status(input logic [4:0] seat, input logic [1:0] st);
    if (seat == 0 || seat > NS) return 1;
    if (st == 2'b10) return 2;
    return 0;
  endfunction

  function automatic int exp_time();
    return (t_base + (cyc - t_n0) / TPM) % MIN_PER_DAY;
  endfunction

  task automatic set_req(input int i, input logic [24:0] s, input logic [4:0] seat, input logic [1:0] st);
    m_valid[i] = 1'b1; m_stu[i] = s; m_seat[i] = seat; m_st[i] = st;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    time_load = 1'b0;
    for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t_base = 0; t_n0 = cyc; m_ptr = 0;
    last_stu = '0; last_seat = '0; last_st = '0;
  endtask

  // One full transaction: wait for the grant, then follow it to its response.
  task automatic service_one(output logic [63:0] obs_id, output logic [63:0] obs_st);
    int w, est;
    bit got;
    logic [24:0] es;
    logic [4:0]  eseat;
    logic [1:0]  estate;
    obs_id = '1; obs_st = '1;
    w = exp_winner();
    got = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.req_ready !== '0) begin got = 1'b1; break; end
    end
    chk("grant_seen", 64'(got), 64'(1));
    chk("winner_exists", 64'(w >= 0), 64'(1));
    if (!got || w < 0) return;
    chk("grant_onehot", 64'(bus.req_ready), 64'(1) << w);
    chk("no_write_in_grant", 64'(write), 64'(0));
    est = model_status(m_seat[w], m_st[w]);
    es = m_stu[w]; eseat = m_seat[w]; estate = m_st[w];
    @(posedge clk); #1;
    m_ptr = (w + 1) % NR;
    m_valid[w] = 1'b0;
    drive();
    @(negedge clk);
    chk("ready_after_grant", 64'(bus.req_ready), 64'(0));
    if (est == 0) begin
      chk("write_strobe", 64'(write), 64'(1));
      chk("write_student", 64'(Student_No), 64'(es));
      chk("write_seat", 64'(Seat_No), 64'(eseat));
      chk("write_state", 64'(Seat_State), 64'(estate));
      chk("no_resp_in_write", 64'(bus.resp_valid), 64'(0));
      last_stu = es; last_seat = eseat; last_st = estate;
      exp_writes++;
      @(negedge clk);
    end
    chk("no_write_in_resp", 64'(write), 64'(0));
    chk("hold_student", 64'(Student_No), 64'(last_stu));
    chk("hold_seat", 64'(Seat_No), 64'(last_seat));
    chk("resp_valid", 64'(bus.resp_valid), 64'(1));
    chk("resp_id", 64'(bus.resp_id), 64'(w));
    chk("resp_status", 64'(bus.resp_status), 64'(est));
    chk("time_model", 64'(Time), 64'(exp_time()));
    obs_id = 64'(bus.resp_id);
    obs_st = 64'(bus.resp_status);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] id, st;
    bit seen;
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0; m_stu[i] = '0; m_seat[i] = '0; m_st[i] = '0;
    end
    do_reset();

    // Reset state
    chk("rst_write", 64'(write), 64'(0));
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_time", 64'(Time), 64'(0));
    chk("rst_student", 64'(Student_No), 64'(0));
    chk("rst_seat", 64'(Seat_No), 64'(0));
    chk("rst_state", 64'(Seat_State), 64'(0));

    // Single valid request from kiosk 0
    set_req(0, 25'h1FFFFFF, 5'd1, 2'b11); drive();
    service_one(id, st);
    chk("single_id", id, 64'(0));
    chk("single_status", st, 64'(0));

    // All kiosks requesting from reset: grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 25'(100 + i), 5'(i + 1), 2'b01);
    drive();
    service_one(id, st); chk("rr_0", id, 64'(0));
    service_one(id, st); chk("rr_1", id, 64'(1));
    service_one(id, st); chk("rr_2", id, 64'(2));
    set_req(0, 25'h0ABCDE, 5'd7, 2'b00); drive();
    service_one(id, st); chk("rr_3", id, 64'(3));
    service_one(id, st); chk("rr_4", id, 64'(0));

    // Rejected requests
    set_req(2, 25'h123, 5'd0, 2'b00); drive();
    service_one(id, st); chk("seat0_status", st, 64'(1));
    set_req(3, 25'h456, 5'd31, 2'b11); drive();
    service_one(id, st); chk("seat31_status", st, 64'(1));
    set_req(1, 25'h789, 5'd5, 2'b10); drive();
    service_one(id, st); chk("state10_status", st, 64'(2));
    set_req(2, 25'h321, 5'd0, 2'b10); drive();
    service_one(id, st); chk("seat_precedence", st, 64'(1));
    set_req(0, 25'h654, 5'd30, 2'b11); drive();
    service_one(id, st); chk("seat30_ok", st, 64'(0));

    // Time: load 1438, then wrap through 1439 to 0
    @(negedge clk); time_load = 1'b1; time_load_val = 11'd1438;
    @(negedge clk); time_load = 1'b0; t_base = 1438; t_n0 = cyc;
    chk("tload_now", 64'(Time), 64'(1438));
    repeat (3) @(negedge clk); chk("tload_3", 64'(Time), 64'(1438));
    @(negedge clk); chk("tload_4", 64'(Time), 64'(1439));
    repeat (4) @(negedge clk); chk("tload_8", 64'(Time), 64'(0));
    // Out-of-range load is ignored, prescaler keeps running
    @(negedge clk); time_load = 1'b1; time_load_val = 11'd1500;
    @(negedge clk); time_load = 1'b0;
    chk("tload_ignored", 64'(Time), 64'(exp_time()));
    repeat (5) @(negedge clk); chk("tload_ignored_run", 64'(Time), 64'(exp_time()));
    // Load in the cycle of a minute tick wins
    while (((cyc - t_n0) % TPM) != TPM - 1) @(negedge clk);
    time_load = 1'b1; time_load_val = 11'd100;
    @(negedge clk); time_load = 1'b0; t_base = 100; t_n0 = cyc;
    chk("tload_vs_tick", 64'(Time), 64'(100));
    repeat (4) @(negedge clk); chk("tload_vs_tick_next", 64'(Time), 64'(101));

    // Reset in the middle of a write
    set_req(1, 25'h55555, 5'd3, 2'b01); drive();
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.req_ready !== '0) begin seen = 1'b1; break; end
    end
    chk("midrst_grant", 64'(seen), 64'(1));
    @(posedge clk); #1;
    m_valid[1] = 1'b0; drive();
    chk("midrst_write_hi", 64'(write), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_write_drop", 64'(write), 64'(0));
    chk("midrst_resp_drop", 64'(bus.resp_valid), 64'(0));
    do_reset();
    chk("midrst_time", 64'(Time), 64'(0));
    chk("midrst_student", 64'(Student_No), 64'(0));
    chk("midrst_no_resp", 64'(bus.resp_valid), 64'(0));
    set_req(2, 25'h2222, 5'd9, 2'b00);
    set_req(0, 25'h1111, 5'd8, 2'b11); drive();
    service_one(id, st); chk("midrst_first", id, 64'(0));
    service_one(id, st); chk("midrst_second", id, 64'(2));

    // Randomized traffic with occasional withdrawals
    for (int it = 0; it < 80; it++) begin
      int any;
      any = 0;
      for (int i = 0; i < NR; i++) begin
        if (!m_valid[i] && $urandom_range(1, 0) == 1) begin
          logic [4:0] seat;
          case ($urandom_range(5, 0))
            0:       seat = 5'd0;
            1:       seat = 5'd31;
            2:       seat = 5'(NS);
            default: seat = 5'($urandom_range(NS, 1));
          endcase
          set_req(i, 25'($urandom), seat, 2'($urandom_range(3, 0)));
        end
        if (m_valid[i]) any++;
      end
      if (any == 0) set_req($urandom_range(NR - 1, 0), 25'($urandom), 5'($urandom_range(NS, 1)), 2'b11);
      drive();
      service_one(id, st);
      if ($urandom_range(3, 0) == 0) begin
        m_valid[$urandom_range(NR - 1, 0)] = 1'b0;
        drive();
      end
    end
    for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
    drive();
    repeat (4) @(negedge clk);

    chk("write_count", 64'(wr_cnt), 64'(exp_writes));
    chk("write_overlap", 64'(overlap), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
